serial_bypass_adder: RTL and testbench

// - Multi-cycle WIDTH-bit adder that streams operands 4 bits per clock through one 4-bit carry-bypass slice.
// - Sits directly upstream of the 4-bit carry-bypass adder and feeds it operand nibbles and carry-in.
// - Registers the carry between slices and assembles the full sum.
// - Valid/ready on input and output; reports how many slices took the bypass path.

---
 rtl/cba_pkg.sv | 20 ++
 rtl/cba4_slice.sv | 29 ++
 rtl/serial_bypass_adder.sv | 99 +++++++++
 tb/tb_serial_bypass_adder.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cba_pkg.sv
// Shared definitions for the serial carry-bypass adder: slice width, FSM states
// and a constant-foldable ceil(log2) used to size counters.
package cba_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/cba4_slice.sv
// 4-bit carry-bypass adder slice: ripple of four full adders, with the carry-out
// taken straight from cin when every bit propagates.
module cba4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       bypass
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    s      = p ^ c[3:0];
    bypass = &p;
    cout   = bypass ? cin : c[4];
  end

endmodule

// File: rtl/serial_bypass_adder.sv
// Multi-cycle WIDTH-bit adder: streams operands one nibble per clock through a
// single carry-bypass slice and assembles the sum LSB-first.
module serial_bypass_adder
  import cba_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  input  logic                                 cin,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [WIDTH-1:0]                     sum,
  output logic                                 cout,
  output logic [clog2(WIDTH/SLICE_W+1)-1:0]    bypass_cnt
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CW     = clog2(NSLICE + 1);

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [3:0]       slice_s;
  logic             slice_cout;
  logic             slice_byp;
  logic             last;
  logic             accept;

  cba4_slice u_slice (
    .a      (a_sh[3:0]),
    .b      (b_sh[3:0]),
    .cin    (carry),
    .s      (slice_s),
    .cout   (slice_cout),
    .bypass (slice_byp)
  );

  assign last      = (cnt == CW'(NSLICE - 1));
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sum fills from the MSB end so that after NSLICE shifts nibble 0 sits at bit 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh       <= '0;
      b_sh       <= '0;
      carry      <= 1'b0;
      sum        <= '0;
      cout       <= 1'b0;
      bypass_cnt <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_sh       <= a;
            b_sh       <= b;
            carry      <= cin;
            bypass_cnt <= '0;
            cnt        <= '0;
          end
        end
        RUN: begin
          a_sh  <= {{SLICE_W{1'b0}}, a_sh[WIDTH-1:SLICE_W]};
          b_sh  <= {{SLICE_W{1'b0}}, b_sh[WIDTH-1:SLICE_W]};
          sum   <= {slice_s, sum[WIDTH-1:SLICE_W]};
          carry <= slice_cout;
          cnt   <= cnt + CW'(1);
          if (slice_byp) bypass_cnt <= bypass_cnt + CW'(1);
          if (last) cout <= slice_cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_bypass_adder.sv
// Bench for serial_bypass_adder: transaction-level reference model checked every
// cycle, plus hand-computed results for the directed cases.
module tb_serial_bypass_adder;

  localparam int W      = 16;
  localparam int NSL    = W / 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  op_a, op_b;
  logic          op_cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic [2:0]    bypass_cnt;

  int total = 0;
  int bad   = 0;

  serial_bypass_adder #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (op_a),
    .b          (op_b),
    .cin        (op_cin),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .bypass_cnt (bypass_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: whole-transaction arithmetic; timing as "busy for NSL edges, then
  // hold the result until out_ready".
  int           m_phase = 0;   // 0 idle, 1 computing, 2 result held
  int           m_left  = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  int           m_byp   = 0;

  always @(posedge clk) begin
    logic [W:0] full;
    logic [W-1:0] x;
    if (rst) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (in_valid) begin
        full   = {1'b0, op_a} + {1'b0, op_b} + (W+1)'(op_cin);
        m_sum  = full[W-1:0];
        m_cout = full[W];
        x      = op_a ^ op_b;
        m_byp  = 0;
        for (int i = 0; i < NSL; i++)
          if (((x >> (4 * i)) & 16'h000F) == 16'h000F) m_byp++;
        m_left  = NSL;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) m_phase = 2;
    end else begin
      if (out_ready) m_phase = 0;
    end
  end

  bit started = 0;
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, (m_phase == 0) && !rst);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2) begin
        chk("sum", sum, m_sum);
        chk("cout", cout, m_cout);
        chk("bypass_cnt", bypass_cnt, m_byp);
      end
    end
  end

  task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic cc,
                    input int hold, input bit junk,
                    output logic [W-1:0] rs, output logic rc, output int rb, output int lat,
                    output logic [W-1:0] ms, output logic mc, output int mb);
    bit ok;
    rs = '0; rc = 1'b0; rb = 0; lat = -1; ms = '0; mc = 1'b0; mb = 0;
    @(posedge clk); #2;
    in_valid = 1'b1; op_a = aa; op_b = bb; op_cin = cc;
    ok = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; return; end
    @(posedge clk); #2;
    in_valid = junk;
    op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom);
    lat = 0; ok = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); lat++;
      #2;
      if (junk) begin op_a = W'($urandom); op_b = W'($urandom); op_cin = 1'($urandom); end
      @(negedge clk);
      if (out_valid) begin ok = 1; break; end
    end
    if (!ok) begin chk("result_timeout", 0, 1); in_valid = 1'b0; return; end
    rs = sum; rc = cout; rb = int'(bypass_cnt);
    ms = m_sum; mc = m_cout; mb = m_byp;
    repeat (hold) @(negedge clk);
    @(posedge clk); #2;
    out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rs, ms;
    logic rc, mc;
    int rb, mb, lat;
    bit ok;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; op_cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_bypass", bypass_cnt, 0);
    started = 1;
    @(posedge clk); #2;
    rst = 1'b0;

    op(16'hCCCC, 16'h3333, 1'b1, 0, 0, rs, rc, rb, lat, ms, mc, mb);
    chk("d1_sum", rs, 16'h0000); chk("d1_cout", rc, 1); chk("d1_byp", rb, 4);
    chk("d1_lat", lat, 4);
    chk("d1_model", {ms, 7'd0, mc, mb[7:0]}, {16'h0000, 7'd0, 1'b1, 8'd4});

    op(16'hCCCC, 16'h3333, 1'b0, 0, 0, rs, rc, rb, lat, ms, mc, mb);
    chk("d2_sum", rs, 16'hFFFF); chk("d2_cout", rc, 0); chk("d2_byp", rb, 4);
    chk("d2_model", {ms, 7'd0, mc, mb[7:0]}, {16'hFFFF, 7'd0, 1'b0, 8'd4});

    op(16'hFFFF, 16'h0001, 1'b0, 0, 0, rs, rc, rb, lat, ms, mc, mb);
    chk("d3_sum", rs, 16'h0000); chk("d3_cout", rc, 1); chk("d3_byp", rb, 3);
    chk("d3_model", {ms, 7'd0, mc, mb[7:0]}, {16'h0000, 7'd0, 1'b1, 8'd3});

    op(16'h1234, 16'h4321, 1'b0, 3, 0, rs, rc, rb, lat, ms, mc, mb);
    chk("d4_sum", rs, 16'h5555); chk("d4_cout", rc, 0); chk("d4_byp", rb, 0);
    chk("d4_model", {ms, 7'd0, mc, mb[7:0]}, {16'h5555, 7'd0, 1'b0, 8'd0});

    // Abort in the second RUN cycle, then confirm no stale carry/shift state.
    @(posedge clk); #2;
    in_valid = 1'b1; op_a = 16'h8000; op_b = 16'h8000; op_cin = 1'b0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) chk("abort_accept_timeout", 0, 1);
    @(posedge clk); #2; in_valid = 1'b0;
    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    repeat (NSL + 2) @(negedge clk);
    op(16'h0001, 16'h0001, 1'b0, 0, 0, rs, rc, rb, lat, ms, mc, mb);
    chk("d5_sum", rs, 16'h0002); chk("d5_cout", rc, 0); chk("d5_byp", rb, 0);

    op(16'hAAAA, 16'h5555, 1'b1, 1, 1, rs, rc, rb, lat, ms, mc, mb);
    chk("d6_sum", rs, 16'h0000); chk("d6_cout", rc, 1); chk("d6_byp", rb, 4);

    for (int i = 0; i < 500; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
         1'($urandom), rs, rc, rb, lat, ms, mc, mb);
      chk("rand_lat", lat, NSL);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
